contador_bcd_4dig: RTL



---
 rtl/contador_bcd_4dig.sv | 128 ++++++++++++
 1 files changed

// File: rtl/contador_bcd_4dig.sv
// Prescaled 4-digit BCD up/down counter with synchronous clamped load and a
// debounced pause/run push-button; feeds the 7-segment display scanner.
module contador_bcd_4dig #(
   parameter int PRESC_MAX  = 9_999_999,
   parameter int DEB_CYCLES = 50_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        up_dn,
   input  logic        load,
   input  logic [15:0] load_val,
   input  logic        pause_btn,
   output logic [15:0] digits,
   output logic        tick,
   output logic        carry,
   output logic        running
);

   localparam int PW = (PRESC_MAX > 0) ? $clog2(PRESC_MAX + 1) : 1;
   localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [PW-1:0] PRESC_TOP = PW'(PRESC_MAX);
   localparam logic [DW-1:0] DEB_TOP   = DW'(DEB_CYCLES - 1);

   logic [PW-1:0] presc;
   logic          count_en;
   logic [15:0]   stepped;
   logic [15:0]   clamped;
   logic          chain;
   logic [3:0]    step_nib;
   logic [3:0]    load_nib;
   logic          sync0;
   logic          sync1;
   logic [DW-1:0] deb_cnt;
   logic          deb_level;

   assign count_en = en && running;

   // Ripple the +1/-1 through the digits; chain still set at the end means every digit wrapped.
   always_comb begin
      stepped = digits;
      chain   = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step_nib = digits[4*i +: 4];
         if (chain) begin
            if (up_dn) begin
               if (step_nib >= 4'd9) begin
                  stepped[4*i +: 4] = 4'd0;
               end else begin
                  stepped[4*i +: 4] = step_nib + 4'd1;
                  chain             = 1'b0;
               end
            end else begin
               if (step_nib == 4'd0) begin
                  stepped[4*i +: 4] = 4'd9;
               end else begin
                  stepped[4*i +: 4] = (step_nib > 4'd9) ? 4'd8 : step_nib - 4'd1;
                  chain             = 1'b0;
               end
            end
         end
      end
   end

   always_comb begin
      clamped  = load_val;
      load_nib = 4'd0;
      for (int i = 0; i < 4; i++) begin
         load_nib = load_val[4*i +: 4];
         clamped[4*i +: 4] = (load_nib > 4'd9) ? 4'd9 : load_nib;
      end
   end

   // Load outranks a step landing in the same cycle; a paused or disabled counter keeps its prescaler phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc  <= '0;
         digits <= 16'h0000;
         tick   <= 1'b0;
         carry  <= 1'b0;
      end else if (load) begin
         presc  <= '0;
         digits <= clamped;
         tick   <= 1'b0;
         carry  <= 1'b0;
      end else if (count_en) begin
         if (presc == PRESC_TOP) begin
            presc  <= '0;
            digits <= stepped;
            tick   <= 1'b1;
            carry  <= chain;
         end else begin
            presc  <= presc + 1'b1;
            tick   <= 1'b0;
            carry  <= 1'b0;
         end
      end else begin
         tick  <= 1'b0;
         carry <= 1'b0;
      end
   end

   // The debounced level only moves after DEB_CYCLES consecutive differing samples; its rising edge flips running.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync0     <= 1'b0;
         sync1     <= 1'b0;
         deb_cnt   <= '0;
         deb_level <= 1'b0;
         running   <= 1'b1;
      end else begin
         sync0 <= pause_btn;
         sync1 <= sync0;
         if (sync1 == deb_level) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DEB_TOP) begin
            deb_cnt   <= '0;
            deb_level <= sync1;
            if (sync1) begin
               running <= ~running;
            end
         end else begin
            deb_cnt <= deb_cnt + 1'b1;
         end
      end
   end

endmodule
